systolic_result_drain: RTL
==========================

# systolic_result_drain

Collects partial-sum results leaving the bottom edge of a systolic array of `basic_pe` columns and turns them into whole rows. Column j emits its result for a given row j cycles after column 0, so the block delays each column to realign the row. It buffers realigned rows in a small FIFO and presents them downstream on a valid/ready handshake. It is the reading end of the array's `result` outputs, the counterpart to the weight/data feeders at the array's top and left edges.

## Interface
- `DATA_WIDTH`, 8, width of one column result (two's complement, passed through unmodified).
- `COLS`, 4, number of array columns (≥1).
- `FIFO_DEPTH`, 4, number of complete rows buffered (≥2, power of two).

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `col_result`  in  COLS*DATA_WIDTH  bottom-row PE `result` values; column j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- `row_valid_in`  in  1  high in the cycle column 0 presents a valid row result; column j presents that row's value j cycles later.
- `out_data`  out  COLS*DATA_WIDTH  head row of FIFO, same column packing as `col_result`.
- `out_valid`  out  1  `out_data` holds a valid row.
- `out_ready`  in  1  downstream accepts; transfer when `out_valid && out_ready`.
- `overflow`  out  1  sticky; a realigned row was dropped.
- `clear_overflow`  in  1  clears `overflow` at the next edge.
- `count`  out  $clog2(FIFO_DEPTH+1)  rows currently in FIFO.

## Operation
- Deskew: column j passes through COLS-1-j register stages; column COLS-1 is not delayed. `row_valid_in` passes through COLS-1 stages to give `aligned_valid`. For COLS=1, no registers are used.
- Aligned row: the deskewed columns plus `aligned_valid`, present in cycle t+COLS-1 for a row flagged at cycle t.
- Push: when `aligned_valid` is high, the aligned row is written at that edge if FIFO not full, or if full and a pop occurs in the same cycle.
- Drop: `aligned_valid` high, FIFO full, no pop in that cycle. The row is discarded, `overflow` set, `count` unchanged.
- Pop: `out_valid && out_ready` advances the read pointer.
- FIFO: circular buffer, wrap-around pointers, show-ahead. `out_data` = memory[rd_ptr]; `out_valid` = (`count` != 0).
- Simultaneous push and pop: `count` unchanged. This holds at full and at any intermediate level.
- Push into empty FIFO: `out_valid` rises the cycle after the push edge. No combinational bypass from input to output.
- `overflow`: set by a drop. `clear_overflow` clears it. If a drop and `clear_overflow` occur in the same cycle, set wins.
- The array cannot stall, so there is no backpressure toward it. `out_ready` never affects the deskew pipeline.
- `col_result` is ignored in cycles it is not expected to be valid; deskew stages capture every cycle regardless.
- Data is never modified: no sign extension, truncation, or arithmetic.

## Timing
- Reset (`rst_n` low at an edge): read/write pointers, `count`, `out_valid`, `overflow`, all deskew valid stages → 0. Deskew data stages and `out_data` contents → 0.
- Reset mid-operation: in-flight rows in the deskew pipe and buffered rows are discarded. No output appears after reset deasserts until a new `row_valid_in`.
- Latency: `row_valid_in` at cycle t with FIFO empty → `out_valid` high in cycle t+COLS, with the complete row.
- Throughput: one row per cycle in and out. Back-to-back `row_valid_in` is legal every cycle.
- `out_data`/`out_valid` hold stable while `out_valid && !out_ready`.

## Test plan
- Single row, COLS=4, DATA_WIDTH=8: `row_valid_in` at c0. Column values: col0=0x11@c0, col1=0x22@c1, col2=0x33@c2, col3=0x44@c3. Required: `out_valid` first high at c4, `out_data`=0x44332211, `count`=1→0 after pop.
- Four back-to-back rows with `out_ready`=1. Row k has every column = k+1. Required: rows 0x01010101..0x04040404 delivered at c4..c7 in order, `overflow`=0.
- `out_ready`=0, five rows injected. Required: `count`=4, 5th row dropped, `overflow`=1. Then `out_ready`=1: first four rows drain in order. `clear_overflow` pulse → `overflow`=0 next cycle.
- FIFO full, `out_ready`=1 in the cycle a fifth row aligns. Required: no drop, `overflow`=0, `count` stays 4, fifth row delivered last.
- `rst_n` low at c2 while a row flagged at c0 is in flight, released at c3. Required: `out_valid`=0 and `count`=0 through c10, `overflow`=0.
- Signed extremes: columns 0x80, 0xFF, 0x7F, 0x00. Required: `out_data`=0x007FFF80, bit-exact.

Source files
------------

// File: rtl/systolic_result_drain_if.sv
// Row-result bus between the systolic array bottom edge and the downstream consumer.
// Input side is unthrottled; output side is a show-ahead valid/ready port.
interface systolic_result_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 4
);
    // Handshake: out_data is meaningful while out_valid is high, and a row transfers
    // on every rising edge where out_valid && out_ready. While out_valid && !out_ready,
    // out_data and out_valid hold. row_valid_in has no ready: the array never stalls.
    logic [COLS*DATA_WIDTH-1:0] col_result;
    logic                       row_valid_in;
    logic [COLS*DATA_WIDTH-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output col_result,
        output row_valid_in,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  col_result,
        input  row_valid_in,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/systolic_result_drain.sv
// Realigns skewed bottom-edge column results into whole rows and buffers them in a
// show-ahead FIFO; rows arriving while the FIFO is full and not popping are dropped.
module systolic_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    systolic_result_drain_if.slave           bus,
    input  logic                             clear_overflow,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);
    localparam int RW = COLS * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic          aligned_valid;
    logic [RW-1:0] aligned_row;

    // Column j arrives j cycles after column 0, so it waits COLS-1-j cycles.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int D = COLS - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = bus.col_result[j*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] stage_q [D];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < D; s++) stage_q[s] <= '0;
                end else begin
                    stage_q[0] <= bus.col_result[j*DATA_WIDTH +: DATA_WIDTH];
                    for (int s = 1; s < D; s++) stage_q[s] <= stage_q[s-1];
                end
            end
            assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = stage_q[D-1];
        end
    end

    if (COLS == 1) begin : g_vpass
        assign aligned_valid = bus.row_valid_in;
    end else begin : g_vpipe
        logic [COLS-2:0] vld_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= bus.row_valid_in;
                for (int s = 1; s < COLS - 1; s++) vld_q[s] <= vld_q[s-1];
            end
        end
        assign aligned_valid = vld_q[COLS-2];
    end

    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, full, drop;

    always_comb begin
        pop        = (count_q != '0) && bus.out_ready;
        full       = (count_q == FULL_CNT);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push       = aligned_valid && (!full || pop);
        drop       = aligned_valid && full && !pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clear_overflow) overflow_d = 1'b0;
        if (drop)           overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= aligned_row;
        end
    end

    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_valid = (count_q != '0);
    assign count         = count_q;
    assign overflow      = overflow_q;
endmodule
